// File: rtl/fft_ctrl_pkg.sv
// Shared constants and types for the FFT frame controller.
package fft_ctrl_pkg;

  localparam int NFFT      = 4096;
  localparam int NFFT_LOG2 = $clog2(NFFT);
  localparam int MIN_BIN   = 1;

  localparam logic [15:0] CFG_WORD = 16'h0001;

  typedef enum logic {
    CFG = 1'b0,
    RUN = 1'b1
  } state_t;

  typedef logic [NFFT_LOG2-1:0] bin_t;
  typedef logic [31:0]          mag_t;

  localparam bin_t BIN_LAST = bin_t'(NFFT - 1);
  localparam bin_t BIN_MIN  = bin_t'(MIN_BIN);
  localparam bin_t BIN_HALF = bin_t'(NFFT / 2);

  // Only bins MIN_BIN..NFFT/2-1 compete for the peak: DC and the mirrored half are ignored.
  function automatic logic is_candidate(input bin_t b);
    return (b >= BIN_MIN) && (b < BIN_HALF);
  endfunction

endpackage

// File: rtl/fft_frame_controller_if.sv
// AXI-stream style links between the frame controller and the FFT core.
//
// Handshake: every channel is valid/ready. A transfer happens on a rising clock
// edge where both valid and ready are high. Once valid is raised, the source
// holds valid, data and last unchanged until that transfer happens; ready may
// change freely and never depends combinationally on valid at the source.
interface fft_frame_controller_if;

  logic [15:0] cfg_tdata;
  logic        cfg_tvalid;
  logic        cfg_tready;

  logic [15:0] fft_s_tdata;
  logic        fft_s_tvalid;
  logic        fft_s_tlast;
  logic        fft_s_tready;

  logic [31:0] fft_m_tdata;
  logic        fft_m_tvalid;
  logic        fft_m_tlast;
  logic        fft_m_tready;

  // Controller side.
  modport master (
    output cfg_tdata, cfg_tvalid,
    input  cfg_tready,
    output fft_s_tdata, fft_s_tvalid, fft_s_tlast,
    input  fft_s_tready,
    input  fft_m_tdata, fft_m_tvalid, fft_m_tlast,
    output fft_m_tready
  );

  // FFT core side.
  modport slave (
    input  cfg_tdata, cfg_tvalid,
    output cfg_tready,
    input  fft_s_tdata, fft_s_tvalid, fft_s_tlast,
    output fft_s_tready,
    output fft_m_tdata, fft_m_tvalid, fft_m_tlast,
    input  fft_m_tready
  );

endinterface

// File: rtl/fft_peak_tracker.sv
// Two-stage magnitude-squared and running-maximum tracker for the FFT output
// stream. Stage 1 squares real and imaginary parts, stage 2 sums, compares
// against the running maximum and publishes the result on the frame's last beat.
module fft_peak_tracker
  import fft_ctrl_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        i_beat,
  input  logic        i_last,
  input  bin_t        i_bin,
  input  logic [31:0] i_data,
  output bin_t        o_peak_bin,
  output mag_t        o_peak_mag,
  output logic        o_peak_valid
);

  logic signed [31:0] w_re32;
  logic signed [31:0] w_im32;
  mag_t               w_sq_re;
  mag_t               w_sq_im;

  logic r_s1_valid;
  logic r_s1_last;
  logic r_s1_cand;
  bin_t r_s1_bin;
  mag_t r_s1_sq_re;
  mag_t r_s1_sq_im;

  logic r_fresh;
  mag_t r_max_mag;
  bin_t r_max_bin;

  mag_t w_sum;
  mag_t w_base_mag;
  bin_t w_base_bin;
  mag_t w_new_mag;
  bin_t w_new_bin;

  // Sign-extend to 32 bits so each square is formed at full width.
  assign w_re32  = {{16{i_data[15]}}, i_data[15:0]};
  assign w_im32  = {{16{i_data[31]}}, i_data[31:16]};
  assign w_sq_re = w_re32 * w_re32;
  assign w_sq_im = w_im32 * w_im32;

  // Stage 1: register the squares along with the bin bookkeeping.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_cand  <= 1'b0;
      r_s1_bin   <= '0;
      r_s1_sq_re <= '0;
      r_s1_sq_im <= '0;
    end else begin
      r_s1_valid <= i_beat;
      r_s1_last  <= i_beat & i_last;
      r_s1_cand  <= is_candidate(i_bin);
      r_s1_bin   <= i_bin;
      r_s1_sq_re <= w_sq_re;
      r_s1_sq_im <= w_sq_im;
    end
  end

  // Stage 2 compare: a fresh frame starts from 0 / MIN_BIN; strictly greater wins so ties keep the lowest bin.
  always_comb begin
    w_sum      = r_s1_sq_re + r_s1_sq_im;
    w_base_mag = r_fresh ? '0 : r_max_mag;
    w_base_bin = r_fresh ? BIN_MIN : r_max_bin;
    w_new_mag  = w_base_mag;
    w_new_bin  = w_base_bin;
    if (r_s1_cand && (w_sum > w_base_mag)) begin
      w_new_mag = w_sum;
      w_new_bin = r_s1_bin;
    end
  end

  // Stage 2 state: update the running max, or publish it and re-arm on the last beat.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_fresh      <= 1'b1;
      r_max_mag    <= '0;
      r_max_bin    <= BIN_MIN;
      o_peak_bin   <= '0;
      o_peak_mag   <= '0;
      o_peak_valid <= 1'b0;
    end else begin
      o_peak_valid <= 1'b0;
      if (r_s1_valid) begin
        if (r_s1_last) begin
          o_peak_bin   <= w_new_bin;
          o_peak_mag   <= w_new_mag;
          o_peak_valid <= 1'b1;
          r_fresh      <= 1'b1;
        end else begin
          r_max_mag <= w_new_mag;
          r_max_bin <= w_new_bin;
          r_fresh   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/fft_frame_controller.sv
// Sequencer for the streaming FFT core: sends the one-time config word, frames
// the audio samples into input beats with tlast, and tracks the per-frame peak
// bin of the output stream.
module fft_frame_controller
  import fft_ctrl_pkg::*;
(
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [7:0]             sample_in,
  input  logic                   sample_valid,
  fft_frame_controller_if.master bus,
  output bin_t                   peak_bin,
  output mag_t                   peak_mag,
  output logic                   peak_valid,
  output logic                   overrun,
  output logic                   frame_err,
  output state_t                 dbg_state
);

  state_t r_state;
  state_t w_state_next;
  logic   r_cfg_arm;
  logic   w_cfg_tvalid;
  logic   w_run;

  logic       r_hold_valid;
  logic [7:0] r_hold_data;
  bin_t       r_in_cnt;
  logic       r_overrun;
  logic       w_s_accept;
  logic       w_load;
  logic       w_drop;

  bin_t r_bin_cnt;
  logic r_frame_err;
  logic w_m_beat;

  // FSM state register; r_cfg_arm keeps cfg_tvalid low in the cycle right after reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state   <= CFG;
      r_cfg_arm <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cfg_arm <= 1'b1;
    end
  end

  // FSM next state and outputs: CFG offers the config word until taken, RUN is terminal.
  always_comb begin
    w_state_next = r_state;
    w_cfg_tvalid = 1'b0;
    w_run        = 1'b0;
    case (r_state)
      CFG: begin
        w_cfg_tvalid = r_cfg_arm;
        if (w_cfg_tvalid && bus.cfg_tready) begin
          w_state_next = RUN;
        end
      end
      RUN: begin
        w_run = 1'b1;
      end
      default: begin
        w_state_next = CFG;
      end
    endcase
  end

  assign bus.cfg_tvalid   = w_cfg_tvalid;
  assign bus.cfg_tdata    = w_cfg_tvalid ? CFG_WORD : 16'h0000;
  assign bus.fft_m_tready = w_run;
  assign dbg_state        = r_state;

  // Input side: a sample may refill the holding register in the same cycle it drains.
  assign w_s_accept = r_hold_valid & bus.fft_s_tready;
  assign w_load     = w_run & sample_valid & (~r_hold_valid | w_s_accept);
  assign w_drop     = w_run & sample_valid & r_hold_valid & ~w_s_accept;

  // Holding register, input frame counter and sticky overrun.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_hold_valid <= 1'b0;
      r_hold_data  <= '0;
      r_in_cnt     <= '0;
      r_overrun    <= 1'b0;
    end else begin
      if (w_load) begin
        r_hold_valid <= 1'b1;
        r_hold_data  <= sample_in;
      end else if (w_s_accept) begin
        r_hold_valid <= 1'b0;
      end
      if (w_s_accept) begin
        r_in_cnt <= r_in_cnt + bin_t'(1);
      end
      if (w_drop) begin
        r_overrun <= 1'b1;
      end
    end
  end

  // The counter only moves on acceptance, so tlast stays stable while a beat waits.
  assign bus.fft_s_tvalid = r_hold_valid;
  assign bus.fft_s_tdata  = {8'h00, r_hold_data};
  assign bus.fft_s_tlast  = r_hold_valid && (r_in_cnt == BIN_LAST);
  assign overrun          = r_overrun;

  assign w_m_beat = bus.fft_m_tvalid & w_run;

  // Output bin counter: resyncs to 0 on tlast; a misplaced or missing tlast sets frame_err.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_bin_cnt   <= '0;
      r_frame_err <= 1'b0;
    end else if (w_m_beat) begin
      if (bus.fft_m_tlast) begin
        if (r_bin_cnt != BIN_LAST) begin
          r_frame_err <= 1'b1;
        end
        r_bin_cnt <= '0;
      end else begin
        if (r_bin_cnt == BIN_LAST) begin
          r_frame_err <= 1'b1;
        end
        r_bin_cnt <= r_bin_cnt + bin_t'(1);
      end
    end
  end

  assign frame_err = r_frame_err;

  fft_peak_tracker u_peak (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .i_beat       (w_m_beat),
    .i_last       (bus.fft_m_tlast),
    .i_bin        (r_bin_cnt),
    .i_data       (bus.fft_m_tdata),
    .o_peak_bin   (peak_bin),
    .o_peak_mag   (peak_mag),
    .o_peak_valid (peak_valid)
  );

endmodule

// File: tb/tb_fft_frame_controller.sv
// Bench for fft_frame_controller: config phase, sample framing, overrun,
// peak detection on directed and random output frames, frame errors and
// mid-frame reset.
module tb_fft_frame_controller;
  import fft_ctrl_pkg::*;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic [7:0] sample_in;
  logic       sample_valid;
  bin_t       peak_bin;
  mag_t       peak_mag;
  logic       peak_valid;
  logic       overrun;
  logic       frame_err;
  state_t     dbg_state;

  fft_frame_controller_if u_if ();

  fft_frame_controller dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .bus          (u_if),
    .peak_bin     (peak_bin),
    .peak_mag     (peak_mag),
    .peak_valid   (peak_valid),
    .overrun      (overrun),
    .frame_err    (frame_err),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_in = ~clk_in;

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [16:0] exp_q[$];   // {tlast, tdata} of input beats
  logic [43:0] pk_q[$];    // {bin, mag} of expected peak results
  int beats_pushed = 0;
  int tlast_seen   = 0;
  int peaks_seen   = 0;
  int frame_re[NFFT];
  int frame_im[NFFT];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Expected input beat: tlast on every NFFT-th accepted beat.
  task automatic push_beat(input logic [7:0] s);
    logic last;
    last = ((beats_pushed % NFFT) == NFFT - 1);
    exp_q.push_back({last, 8'h00, s});
    beats_pushed++;
  endtask

  // Reference peak over the first n bins of the frame arrays.
  function automatic logic [43:0] ref_peak(input int n);
    longint best;
    int     bb;
    longint m;
    best = 0;
    bb   = MIN_BIN;
    for (int j = MIN_BIN; j < n && j < NFFT / 2; j++) begin
      m = longint'(frame_re[j]) * frame_re[j] + longint'(frame_im[j]) * frame_im[j];
      if (m > best) begin
        best = m;
        bb   = j;
      end
    end
    return {12'(bb), 32'(best)};
  endfunction

  task automatic fill_zero();
    for (int j = 0; j < NFFT; j++) begin
      frame_re[j] = 0;
      frame_im[j] = 0;
    end
  endtask

  task automatic fill_random();
    logic [15:0] t;
    for (int j = 0; j < NFFT; j++) begin
      t = 16'($urandom);
      frame_re[j] = int'($signed(t));
      t = 16'($urandom);
      frame_im[j] = int'($signed(t));
    end
  endtask

  // Driver: n output beats back to back, tlast on the final one when with_last.
  task automatic send_out(input int n, input logic with_last);
    logic [15:0] re16;
    logic [15:0] im16;
    for (int j = 0; j < n; j++) begin
      re16 = 16'(frame_re[j]);
      im16 = 16'(frame_im[j]);
      u_if.fft_m_tvalid = 1'b1;
      u_if.fft_m_tdata  = {im16, re16};
      u_if.fft_m_tlast  = with_last && (j == n - 1);
      step();
    end
    u_if.fft_m_tvalid = 1'b0;
    u_if.fft_m_tlast  = 1'b0;
  endtask

  // Input-side monitor: every accepted beat must match the head of exp_q.
  always @(negedge clk_in) begin
    logic [16:0] e;
    if (u_if.fft_s_tvalid === 1'b1 && u_if.fft_s_tready === 1'b1) begin
      check("s_beat_expected", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("s_beat", 64'({u_if.fft_s_tlast, u_if.fft_s_tdata}), 64'(e));
        if (u_if.fft_s_tlast === 1'b1) tlast_seen++;
      end
    end
  end

  // Peak monitor: every peak_valid pulse must match the head of pk_q.
  always @(negedge clk_in) begin
    logic [43:0] e;
    if (peak_valid === 1'b1) begin
      peaks_seen++;
      check("peak_expected", 64'(pk_q.size() != 0), 64'(1));
      if (pk_q.size() != 0) begin
        e = pk_q.pop_front();
        check("peak_bin", 64'(peak_bin), 64'(e[43:32]));
        check("peak_mag", 64'(peak_mag), 64'(e[31:0]));
      end
    end
  end

  // Watchdog.
  initial begin
    #900000;
    bad++;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [7:0] a;
    logic [7:0] s;

    rst_in            = 1'b1;
    sample_in         = '0;
    sample_valid      = 1'b0;
    u_if.cfg_tready   = 1'b0;
    u_if.fft_s_tready = 1'b1;
    u_if.fft_m_tvalid = 1'b0;
    u_if.fft_m_tlast  = 1'b0;
    u_if.fft_m_tdata  = '0;
    repeat (3) step();

    // Reset state.
    @(negedge clk_in);
    check("rst_cfg_tvalid", 64'(u_if.cfg_tvalid), 64'(0));
    check("rst_m_tready", 64'(u_if.fft_m_tready), 64'(0));
    check("rst_s_tvalid", 64'(u_if.fft_s_tvalid), 64'(0));
    check("rst_peak_valid", 64'(peak_valid), 64'(0));
    check("rst_peak_mag", 64'(peak_mag), 64'(0));
    check("rst_overrun", 64'(overrun), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(CFG));
    step();
    rst_in = 1'b0;
    step();

    // Config phase: ready low 5 cycles then high; samples pulse every cycle and are dropped.
    for (int i = 0; i < 6; i++) begin
      u_if.cfg_tready = (i == 5);
      sample_valid    = 1'b1;
      sample_in       = 8'($urandom);
      @(negedge clk_in);
      check("cfg_tvalid", 64'(u_if.cfg_tvalid), 64'(1));
      check("cfg_tdata", 64'(u_if.cfg_tdata), 64'(16'h0001));
      check("cfg_no_s_beat", 64'(u_if.fft_s_tvalid), 64'(0));
      step();
    end
    u_if.cfg_tready = 1'b0;
    sample_valid    = 1'b0;
    @(negedge clk_in);
    check("cfg_done_tvalid", 64'(u_if.cfg_tvalid), 64'(0));
    check("run_state", 64'(dbg_state), 64'(RUN));
    check("run_m_tready", 64'(u_if.fft_m_tready), 64'(1));
    check("cfg_overrun", 64'(overrun), 64'(0));
    step();

    // Two input frames, one sample every 4 cycles.
    for (int f = 0; f < 2 * NFFT; f++) begin
      s = 8'($urandom);
      push_beat(s);
      sample_in    = s;
      sample_valid = 1'b1;
      step();
      sample_valid = 1'b0;
      repeat (3) step();
    end
    repeat (3) step();
    check("in_q_drained", 64'(exp_q.size()), 64'(0));
    check("in_tlast_count", 64'(tlast_seen), 64'(2));
    check("in_overrun", 64'(overrun), 64'(0));

    // Overrun: ready low 3 cycles with a sample every cycle.
    u_if.fft_s_tready = 1'b0;
    a = 8'($urandom);
    push_beat(a);
    sample_in    = a;
    sample_valid = 1'b1;
    step();
    sample_in = 8'($urandom);
    @(negedge clk_in);
    check("ovr_hold_valid", 64'(u_if.fft_s_tvalid), 64'(1));
    check("ovr_hold_data1", 64'(u_if.fft_s_tdata), 64'({8'h00, a}));
    check("ovr_not_yet", 64'(overrun), 64'(0));
    step();
    sample_in = 8'($urandom);
    @(negedge clk_in);
    check("ovr_hold_data2", 64'(u_if.fft_s_tdata), 64'({8'h00, a}));
    check("ovr_set", 64'(overrun), 64'(1));
    step();
    sample_valid      = 1'b0;
    u_if.fft_s_tready = 1'b1;
    @(negedge clk_in);
    check("ovr_hold_data3", 64'(u_if.fft_s_tdata), 64'({8'h00, a}));
    repeat (4) step();
    check("ovr_sticky", 64'(overrun), 64'(1));
    check("ovr_q_drained", 64'(exp_q.size()), 64'(0));

    // Output frame 1: single peak at bin 100, with peak_valid timing.
    fill_zero();
    frame_re[100] = 300;
    frame_im[100] = -400;
    pk_q.push_back({12'd100, 32'd250000});
    send_out(NFFT, 1'b1);
    @(negedge clk_in);
    check("pk1_early", 64'(peak_valid), 64'(0));
    step();
    @(negedge clk_in);
    check("pk1_valid", 64'(peak_valid), 64'(1));
    check("pk1_bin", 64'(peak_bin), 64'(100));
    check("pk1_mag", 64'(peak_mag), 64'(250000));
    step();
    @(negedge clk_in);
    check("pk1_pulse_end", 64'(peak_valid), 64'(0));
    check("pk1_hold", 64'(peak_bin), 64'(100));
    step();

    // Output frame 2: DC excluded, tie keeps lowest bin.
    fill_zero();
    frame_re[0]  = 30000;
    frame_re[50] = 100;
    frame_re[70] = 100;
    pk_q.push_back({12'd50, 32'd10000});
    send_out(NFFT, 1'b1);
    repeat (4) step();
    check("frame_err_clean", 64'(frame_err), 64'(0));

    // Frames 3 (random), 4 (tlast at bin 2000), 5 (random) back to back.
    fill_random();
    pk_q.push_back(ref_peak(NFFT));
    send_out(NFFT, 1'b1);
    fill_random();
    pk_q.push_back(ref_peak(2001));
    send_out(2001, 1'b1);
    fill_random();
    pk_q.push_back(ref_peak(NFFT));
    send_out(NFFT, 1'b1);
    repeat (4) step();
    check("frame_err_set", 64'(frame_err), 64'(1));
    check("pk_q_drained", 64'(pk_q.size()), 64'(0));
    check("peaks_seen", 64'(peaks_seen), 64'(5));

    // Mid-frame reset with an output frame and a held sample in flight.
    fill_random();
    send_out(1000, 1'b0);
    u_if.fft_s_tready = 1'b0;
    sample_in         = 8'($urandom);
    sample_valid      = 1'b1;
    step();
    sample_valid = 1'b0;
    @(negedge clk_in);
    check("mid_hold_full", 64'(u_if.fft_s_tvalid), 64'(1));
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    @(negedge clk_in);
    check("mid_rst_state", 64'(dbg_state), 64'(CFG));
    check("mid_rst_cfg_tvalid", 64'(u_if.cfg_tvalid), 64'(0));
    check("mid_rst_s_bus", 64'({u_if.fft_s_tvalid, u_if.fft_s_tlast, u_if.fft_s_tdata}), 64'(0));
    check("mid_rst_m_tready", 64'(u_if.fft_m_tready), 64'(0));
    check("mid_rst_peak", 64'({peak_valid, peak_bin, peak_mag}), 64'(0));
    check("mid_rst_flags", 64'({overrun, frame_err}), 64'(0));
    repeat (4) step();
    check("mid_rst_cfg_again", 64'(u_if.cfg_tvalid), 64'(1));
    check("mid_rst_no_peak", 64'(peaks_seen), 64'(5));
    u_if.fft_s_tready = 1'b1;

    // Final report.
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
